// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host transmit path.
package ps2_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE,
        S_ERROR
    } ps2_state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_START_TO = 2'b01;
    localparam logic [1:0] ERR_PKT_TO   = 2'b10;
    localparam logic [1:0] ERR_NO_ACK   = 2'b11;

    function automatic int unsigned us_to_cycles(input longint unsigned clk_freq,
                                                 input longint unsigned us);
        return 32'((clk_freq / 64'd1_000_000) * us);
    endfunction

endpackage

// File: rtl/ps2_edge_filter.sv
// PS/2 pin conditioning: 2-FF synchronizers, a run-length clock filter and
// a one-cycle strobe on each accepted falling edge of the filtered clock.
module ps2_edge_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_i,
    input  logic dat_i,
    output logic clk_o,
    output logic dat_o,
    output logic fall_o
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [1:0]       csync_q;
    logic [1:0]       dsync_q;
    logic             flt_q, flt_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A new level is accepted only after FILTER_LEN consecutive samples disagree
    // with the current filtered level; any agreeing sample restarts the run.
    always_comb begin
        cnt_d  = '0;
        flt_d  = flt_q;
        fall_d = 1'b0;
        if (csync_q[1] != flt_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                flt_d  = csync_q[1];
                fall_d = ~csync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csync_q <= 2'b11;
            dsync_q <= 2'b11;
            flt_q   <= 1'b1;
            cnt_q   <= '0;
            fall_q  <= 1'b0;
        end else begin
            csync_q <= {csync_q[0], clk_i};
            dsync_q <= {dsync_q[0], dat_i};
            flt_q   <= flt_d;
            cnt_q   <= cnt_d;
            fall_q  <= fall_d;
        end
    end

    assign clk_o  = flt_q;
    assign dat_o  = dsync_q[1];
    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter. The pad ring turns the oe outputs
// into open-drain drivers: pin = oe ? 0 : 'z.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ          = 50_000_000,
    parameter int INHIBIT_US        = 100,
    parameter int START_TIMEOUT_US  = 15000,
    parameter int PACKET_TIMEOUT_US = 2000,
    parameter int FILTER_LEN        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] err_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned INH_CYC   = us_to_cycles(64'(CLK_FREQ), 64'(INHIBIT_US));
    localparam int unsigned START_CYC = us_to_cycles(64'(CLK_FREQ), 64'(START_TIMEOUT_US));
    localparam int unsigned PKT_CYC   = us_to_cycles(64'(CLK_FREQ), 64'(PACKET_TIMEOUT_US));
    localparam int unsigned MAX_A     = (INH_CYC > START_CYC) ? INH_CYC : START_CYC;
    localparam int unsigned MAX_CYC   = (MAX_A > PKT_CYC) ? MAX_A : PKT_CYC;
    localparam int          TMR_W     = $clog2(MAX_CYC + 1);

    ps2_state_e       state_q, state_d;
    logic [8:0]       shreg_q, shreg_d;
    logic [3:0]       bit_q, bit_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [TMR_W-1:0] pkt_q, pkt_d;
    logic [1:0]       err_q, err_d;

    logic clk_f, dat_s, fall;
    logic pkt_exp;

    ps2_edge_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filt (
        .clk   (clk),
        .reset (reset),
        .clk_i (ps2_clk_in),
        .dat_i (ps2_dat_in),
        .clk_o (clk_f),
        .dat_o (dat_s),
        .fall_o(fall)
    );

    assign pkt_exp  = (pkt_q == TMR_W'(PKT_CYC - 1));
    assign err_code = err_q;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_d      = bit_q;
        tmr_d      = tmr_q;
        pkt_d      = pkt_q;
        err_d      = err_q;
        tx_ready   = 1'b0;
        tx_done    = 1'b0;
        tx_error   = 1'b0;
        ps2_clk_oe = 1'b0;
        ps2_dat_oe = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    shreg_d = {~^tx_data, tx_data};
                    err_d   = ERR_NONE;
                    tmr_d   = '0;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (tmr_q == TMR_W'(INH_CYC - 1)) begin
                    tmr_d   = '0;
                    state_d = S_START;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_START: begin
                ps2_dat_oe = 1'b1;
                if (tmr_q == TMR_W'(START_CYC - 1)) begin
                    err_d   = ERR_START_TO;
                    state_d = S_ERROR;
                end else if (fall) begin
                    bit_d   = '0;
                    pkt_d   = '0;
                    state_d = S_SEND;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            // shreg_q[0] is the bit on the wire; ones shift in so the stop bit
            // (released line) follows the parity bit naturally.
            S_SEND: begin
                ps2_dat_oe = ~shreg_q[0];
                pkt_d      = pkt_q + 1'b1;
                if (pkt_exp) begin
                    err_d   = ERR_PKT_TO;
                    state_d = S_ERROR;
                end else if (fall) begin
                    shreg_d = {1'b1, shreg_q[8:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 4'd8) state_d = S_ACK;
                end
            end
            S_ACK: begin
                pkt_d = pkt_q + 1'b1;
                if (pkt_exp) begin
                    err_d   = ERR_PKT_TO;
                    state_d = S_ERROR;
                end else if (fall) begin
                    if (!dat_s) begin
                        state_d = S_WAIT_IDLE;
                    end else begin
                        err_d   = ERR_NO_ACK;
                        state_d = S_ERROR;
                    end
                end
            end
            S_WAIT_IDLE: begin
                pkt_d = pkt_q + 1'b1;
                if (pkt_exp) begin
                    err_d   = ERR_PKT_TO;
                    state_d = S_ERROR;
                end else if (clk_f && dat_s) begin
                    tx_done = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ERROR: begin
                tx_error = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            shreg_q <= '1;
            bit_q   <= '0;
            tmr_q   <= '0;
            pkt_q   <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            tmr_q   <= tmr_d;
            pkt_q   <= pkt_d;
            err_q   <= err_d;
        end
    end

endmodule
